// File: rtl/pc_seq.sv
// Program counter sequencer with a return-address stack.
// Supports increment, conditional relative branch, absolute jump, call and return,
// with sticky overflow/underflow flags for stack misuse.
module pc_seq #(
    parameter int unsigned    AW       = 16,
    parameter int unsigned    DW       = 8,
    parameter int unsigned    DEPTH    = 4,
    parameter logic [AW-1:0]  RESET_PC = '0,
    localparam int unsigned   PW       = $clog2(DEPTH),
    localparam int unsigned   LW       = PW + 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          en,
    input  logic [2:0]    op,
    input  logic          cond,
    input  logic [DW-1:0] disp,
    input  logic [AW-1:0] target,
    input  logic          clr_err,
    output logic [AW-1:0] pc,
    output logic [AW-1:0] link,
    output logic [LW-1:0] level,
    output logic          empty,
    output logic          full,
    output logic          ovf,
    output logic          unf
);

    typedef enum logic [2:0] {
        OpInc  = 3'b000,
        OpBr   = 3'b001,
        OpJmp  = 3'b010,
        OpCall = 3'b011,
        OpRet  = 3'b100
    } op_e;

    logic [AW-1:0] pc_q, pc_d;
    logic [LW-1:0] level_q, level_d;
    logic          ovf_q, ovf_d;
    logic          unf_q, unf_d;
    logic [AW-1:0] stack_q [DEPTH];
    logic [AW-1:0] stack_d [DEPTH];

    logic [AW-1:0] pc_inc;
    logic [AW-1:0] disp_sx;
    logic [PW-1:0] top_idx;
    logic          ovf_set;
    logic          unf_set;

    // Stack status and top-of-stack view; link is forced to 0 while empty so
    // stale storage never leaks out after a pop or reset.
    always_comb begin
        empty   = (level_q == '0);
        full    = (level_q == LW'(DEPTH));
        top_idx = PW'(level_q - LW'(1));
        link    = empty ? '0 : stack_q[top_idx];
    end

    // Next-state selection for pc, stack and error flags.
    always_comb begin
        pc_inc  = pc_q + AW'(1);
        disp_sx = AW'($signed(disp));
        pc_d    = pc_q;
        level_d = level_q;
        stack_d = stack_q;
        ovf_set = 1'b0;
        unf_set = 1'b0;
        if (en) begin
            case (op)
                OpInc: pc_d = pc_inc;
                OpBr:  pc_d = cond ? (pc_q + disp_sx) : pc_inc;
                OpJmp: pc_d = target;
                OpCall: begin
                    pc_d = target;
                    if (full) begin
                        ovf_set = 1'b1;
                    end else begin
                        // level_q < DEPTH here, so its low bits index the free slot
                        stack_d[level_q[PW-1:0]] = pc_inc;
                        level_d = level_q + LW'(1);
                    end
                end
                OpRet: begin
                    if (empty) begin
                        pc_d    = pc_inc;
                        unf_set = 1'b1;
                    end else begin
                        pc_d    = stack_q[top_idx];
                        level_d = level_q - LW'(1);
                    end
                end
                default: ;
            endcase
        end
        // A fresh error beats a simultaneous clear; clear works even with en=0.
        ovf_d = ovf_set | (ovf_q & ~clr_err);
        unf_d = unf_set | (unf_q & ~clr_err);
    end

    // Control state with asynchronous reset; stack contents are abandoned via level.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pc_q    <= RESET_PC;
            level_q <= '0;
            ovf_q   <= 1'b0;
            unf_q   <= 1'b0;
        end else begin
            pc_q    <= pc_d;
            level_q <= level_d;
            ovf_q   <= ovf_d;
            unf_q   <= unf_d;
        end
    end

    // Stack storage needs no reset: entries above level are never observed.
    always_ff @(posedge clk) begin
        stack_q <= stack_d;
    end

    // Registered outputs.
    always_comb begin
        pc    = pc_q;
        level = level_q;
        ovf   = ovf_q;
        unf   = unf_q;
    end

endmodule

// File: tb/tb_pc_seq.sv
// Self-checking bench for pc_seq using a queue-based reference model.
module tb_pc_seq;

    logic        clk, rst, en, cond, clr_err;
    logic [2:0]  op;
    logic [7:0]  disp;
    logic [15:0] target, pc, link;
    logic [2:0]  level;
    logic        empty, full, ovf, unf;

    int checks = 0;
    int errors = 0;

    // Reference model
    logic [15:0] m_pc;
    logic [15:0] m_stk[$];
    logic        m_ovf, m_unf;

    pc_seq dut (
        .clk     (clk),
        .rst     (rst),
        .en      (en),
        .op      (op),
        .cond    (cond),
        .disp    (disp),
        .target  (target),
        .clr_err (clr_err),
        .pc      (pc),
        .link    (link),
        .level   (level),
        .empty   (empty),
        .full    (full),
        .ovf     (ovf),
        .unf     (unf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic void model_reset();
        m_pc = 16'h0000;
        m_stk.delete();
        m_ovf = 1'b0;
        m_unf = 1'b0;
    endfunction

    function automatic void model_step(input logic e, input logic [2:0] o, input logic c,
                                       input logic [7:0] d, input logic [15:0] t,
                                       input logic cl);
        logic new_ovf, new_unf;
        int   sum;
        new_ovf = 1'b0;
        new_unf = 1'b0;
        if (e) begin
            case (o)
                3'd0: m_pc = m_pc + 16'd1;
                3'd1: begin
                    sum  = int'(m_pc) + int'($signed(d));
                    m_pc = c ? 16'(sum & 32'hFFFF) : m_pc + 16'd1;
                end
                3'd2: m_pc = t;
                3'd3: begin
                    if (m_stk.size() < 4) m_stk.push_back(m_pc + 16'd1);
                    else new_ovf = 1'b1;
                    m_pc = t;
                end
                3'd4: begin
                    if (m_stk.size() > 0) m_pc = m_stk.pop_back();
                    else begin
                        m_pc    = m_pc + 16'd1;
                        new_unf = 1'b1;
                    end
                end
                default: ;
            endcase
        end
        m_ovf = new_ovf | (m_ovf & ~cl);
        m_unf = new_unf | (m_unf & ~cl);
    endfunction

    function automatic logic [38:0] exp_vec();
        logic [15:0] l;
        int          n;
        n = m_stk.size();
        l = (n > 0) ? m_stk[n-1] : 16'h0000;
        return {m_pc, l, 3'(n), (n == 0), (n == 4), m_ovf, m_unf};
    endfunction

    function automatic logic [38:0] obs_vec();
        return {pc, link, level, empty, full, ovf, unf};
    endfunction

    // One clock with the given inputs; model advances on the same edge, sample at +1.
    task automatic drive(input logic e, input logic [2:0] o, input logic c, input logic [7:0] d,
                         input logic [15:0] t, input logic cl);
        en = e; op = o; cond = c; disp = d; target = t; clr_err = cl;
        @(posedge clk);
        model_step(e, o, c, d, t, cl);
        #1;
        en = 1'b0; op = 3'd0; clr_err = 1'b0;
    endtask

    task automatic apply_reset();
        rst = 1'b0;
        #2;
        model_reset();
        rst = 1'b1;
    endtask

    task automatic test_reset();
        rst = 1'b0; en = 0; op = 0; cond = 0; disp = 0; target = 0; clr_err = 0;
        model_reset();
        #2;
        checks++;
        if (obs_vec() !== {16'h0, 16'h0, 3'd0, 1'b1, 1'b0, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL reset_state got %h want %h", obs_vec(), exp_vec());
        end
        #1 rst = 1'b1;
    endtask

    task automatic test_inc_hold();
        for (int i = 0; i < 3; i++) begin
            drive(1, 3'd0, 0, 0, 0, 0);
            checks++;
            if (pc !== 16'(i + 1) || obs_vec() !== exp_vec()) begin
                errors++;
                $display("FAIL inc_%0d got pc=%h want %h", i, pc, 16'(i + 1));
            end
        end
        for (int i = 0; i < 2; i++) begin
            drive(0, 3'd0, 0, 0, 16'h1234, 0);
            checks++;
            if (pc !== 16'd3 || obs_vec() !== exp_vec()) begin
                errors++;
                $display("FAIL hold_%0d got pc=%h want 0003", i, pc);
            end
        end
    endtask

    task automatic test_branch();
        drive(1, 3'd2, 0, 0, 16'h0010, 0);
        drive(1, 3'd1, 1, 8'hFE, 0, 0);
        checks++;
        if (pc !== 16'h000E || obs_vec() !== exp_vec()) begin
            errors++;
            $display("FAIL br_taken got pc=%h want 000E", pc);
        end
        drive(1, 3'd2, 0, 0, 16'h0010, 0);
        drive(1, 3'd1, 0, 8'hFE, 0, 0);
        checks++;
        if (pc !== 16'h0011 || obs_vec() !== exp_vec()) begin
            errors++;
            $display("FAIL br_not_taken got pc=%h want 0011", pc);
        end
        drive(1, 3'd2, 0, 0, 16'hFFFF, 0);
        drive(1, 3'd0, 0, 0, 0, 0);
        checks++;
        if (pc !== 16'h0000 || ovf !== 1'b0 || unf !== 1'b0 || obs_vec() !== exp_vec()) begin
            errors++;
            $display("FAIL inc_wrap got pc=%h ovf=%b unf=%b want 0000 0 0", pc, ovf, unf);
        end
        drive(1, 3'd1, 1, 8'hFF, 0, 0);
        checks++;
        if (pc !== 16'hFFFF || obs_vec() !== exp_vec()) begin
            errors++;
            $display("FAIL br_wrap_back got pc=%h want FFFF", pc);
        end
    endtask

    task automatic test_call_ret();
        drive(1, 3'd2, 0, 0, 16'h0005, 0);
        drive(1, 3'd3, 0, 0, 16'h0100, 0);
        checks++;
        if (pc !== 16'h0100 || link !== 16'h0006 || level !== 3'd1 || obs_vec() !== exp_vec()) begin
            errors++;
            $display("FAIL call got pc=%h link=%h level=%0d want 0100 0006 1", pc, link, level);
        end
        drive(1, 3'd4, 0, 0, 0, 0);
        checks++;
        if (pc !== 16'h0006 || level !== 3'd0 || empty !== 1'b1 || link !== 16'h0 ||
            obs_vec() !== exp_vec()) begin
            errors++;
            $display("FAIL ret got pc=%h level=%0d empty=%b link=%h want 0006 0 1 0000",
                     pc, level, empty, link);
        end
    endtask

    task automatic test_overflow_underflow();
        apply_reset();
        for (int k = 0; k < 5; k++) begin
            drive(1, 3'd3, 0, 0, 16'h1000 + 16'(k * 16), 0);
            checks++;
            if (obs_vec() !== exp_vec() || full !== (k >= 3) || ovf !== (k == 4)) begin
                errors++;
                $display("FAIL call_%0d got %h want %h", k, obs_vec(), exp_vec());
            end
        end
        checks++;
        if (link !== 16'h1021 || pc !== 16'h1040) begin
            errors++;
            $display("FAIL ovf_link got link=%h pc=%h want 1021 1040", link, pc);
        end
        for (int k = 0; k < 5; k++) begin
            drive(1, 3'd4, 0, 0, 0, 0);
            checks++;
            if (obs_vec() !== exp_vec()) begin
                errors++;
                $display("FAIL ret_%0d got %h want %h", k, obs_vec(), exp_vec());
            end
        end
        checks++;
        if (pc !== 16'h0002 || unf !== 1'b1 || level !== 3'd0) begin
            errors++;
            $display("FAIL unf_ret got pc=%h unf=%b level=%0d want 0002 1 0", pc, unf, level);
        end
    endtask

    task automatic test_clr_err();
        drive(0, 3'd3, 0, 0, 16'hAAAA, 1);
        checks++;
        if (ovf !== 1'b0 || unf !== 1'b0 || pc !== 16'h0002 || obs_vec() !== exp_vec()) begin
            errors++;
            $display("FAIL clr_no_en got ovf=%b unf=%b pc=%h want 0 0 0002", ovf, unf, pc);
        end
        for (int k = 0; k < 4; k++) drive(1, 3'd3, 0, 0, 16'h2000 + 16'(k), 0);
        drive(1, 3'd3, 0, 0, 16'h3000, 1);
        checks++;
        if (ovf !== 1'b1 || pc !== 16'h3000 || level !== 3'd4 || obs_vec() !== exp_vec()) begin
            errors++;
            $display("FAIL clr_vs_ovf got ovf=%b pc=%h level=%0d want 1 3000 4", ovf, pc, level);
        end
    endtask

    task automatic test_async_reset();
        apply_reset();
        drive(1, 3'd4, 0, 0, 0, 0);
        drive(1, 3'd3, 0, 0, 16'h0040, 0);
        drive(1, 3'd3, 0, 0, 16'h0080, 0);
        checks++;
        if (level !== 3'd2 || unf !== 1'b1 || obs_vec() !== exp_vec()) begin
            errors++;
            $display("FAIL pre_reset got %h want %h", obs_vec(), exp_vec());
        end
        #2 rst = 1'b0;
        #1;
        checks++;
        if (obs_vec() !== {16'h0, 16'h0, 3'd0, 1'b1, 1'b0, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL async_reset got %h want %h", obs_vec(),
                     {16'h0, 16'h0, 3'd0, 1'b1, 1'b0, 1'b0, 1'b0});
        end
        model_reset();
        #1 rst = 1'b1;
        drive(1, 3'd4, 0, 0, 0, 0);
        checks++;
        if (pc !== 16'h0001 || unf !== 1'b1 || level !== 3'd0 || obs_vec() !== exp_vec()) begin
            errors++;
            $display("FAIL post_reset_ret got pc=%h unf=%b level=%0d want 0001 1 0",
                     pc, unf, level);
        end
    endtask

    task automatic test_random();
        logic        e, c, cl;
        logic [2:0]  o;
        logic [7:0]  d;
        logic [15:0] t;
        apply_reset();
        for (int i = 0; i < 400; i++) begin
            e  = ($urandom % 8) != 0;
            o  = 3'($urandom % 8);
            c  = 1'($urandom);
            d  = 8'($urandom);
            t  = 16'($urandom);
            cl = ($urandom % 6) == 0;
            drive(e, o, c, d, t, cl);
            checks++;
            if (obs_vec() !== exp_vec()) begin
                errors++;
                $display("FAIL random_%0d op=%0d en=%b got %h want %h", i, o, e, obs_vec(),
                         exp_vec());
            end
        end
    endtask

    initial begin
        test_reset();
        test_inc_hold();
        test_branch();
        test_call_ret();
        test_overflow_underflow();
        test_clr_err();
        test_async_reset();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/pc_seq.md
PC_SEQ -- requirements
Module: pc_seq

Interface
REQ-001: The block SHALL have parameter AW, default 16, meaning program counter and address width.
REQ-002: The block SHALL have parameter DW, default 8, meaning branch displacement width, signed two's complement.
REQ-003: The block SHALL have parameter DEPTH, default 4, meaning return-address stack entries (power of two, >=2).
REQ-004: The block SHALL have parameter RESET_PC, default 0, meaning PC value after reset.
REQ-005: The block SHALL use one clock, clk; reset rst is asynchronous and active-low.
REQ-006: Port list (name direction width meaning), in order:
- clk  in  1  clock, rising edge
- rst  in  1  async active-low reset
- en  in  1  PC update enable, as PCe
- op  in  3  000 INC, 001 BR, 010 JMP, 011 CALL, 100 RET, others HOLD
- cond  in  1  branch condition, decoded from flags upstream
- disp  in  DW  signed branch displacement
- target  in  AW  absolute jump/call target, from register bus B
- clr_err  in  1  synchronous clear of sticky errors
- pc  out  AW  current PC, registered
- link  out  AW  top-of-stack return address, 0 when empty
- level  out  clog2(DEPTH)+1  stack occupancy
- empty, full  out  1  stack status, combinational from level
- ovf, unf  out  1  sticky overflow / underflow errors

Function
REQ-007: All state SHALL update only on the rising clk edge when en=1; en=0 SHALL hold pc, stack, level and errors (clr_err excepted).
REQ-008: pc SHALL reflect the selected next value exactly one cycle after the enabled edge; no combinational path from inputs to pc.
REQ-009: INC SHALL set pc <= pc+1.
REQ-010: BR with cond=1 SHALL set pc <= pc + sign_extend(disp); BR with cond=0 SHALL set pc <= pc+1.
REQ-011: JMP SHALL set pc <= target.
REQ-012: CALL SHALL push pc+1 onto the stack, increment level and set pc <= target.
REQ-013: RET SHALL set pc <= top entry, pop it and decrement level.
REQ-014: HOLD codes (101,110,111) SHALL leave pc and stack unchanged.
REQ-015: All PC arithmetic SHALL be modulo 2^AW: wrap at all-ones to 0 and at 0 backwards to all-ones, with no flag raised.
REQ-016: CALL when full SHALL still jump to target, SHALL drop the push, SHALL leave level at DEPTH and SHALL set ovf.
REQ-017: RET when empty SHALL set pc <= pc+1, SHALL leave level at 0 and SHALL set unf.
REQ-018: Stack SHALL be LIFO; link SHALL equal the most recently pushed, unpopped entry.
REQ-019: empty SHALL be 1 iff level=0; full SHALL be 1 iff level=DEPTH.
REQ-020: ovf and unf SHALL remain set until clr_err=1 at a clock edge; clr_err SHALL act regardless of en.
REQ-021: When clr_err coincides with a new overflow or underflow, the new error SHALL win and the flag SHALL stay 1.

Reset
REQ-022: rst=0 SHALL immediately, without a clock, force pc=RESET_PC, level=0, link=0, ovf=0, unf=0, empty=1, full=0.
REQ-023: Stack storage contents need not be cleared, but link SHALL read 0 whenever empty.
REQ-024: Reset asserted mid-sequence SHALL abandon any in-flight stack contents; the first enabled edge after rst release SHALL use the reset values.

Verification
REQ-025: Reset then 3 enabled INC cycles -> pc 0,1,2,3; en=0 for 2 cycles -> pc holds at 3.
REQ-026: pc=0x0010, BR with disp=0xFE, cond=1 -> pc=0x000E; same setup with cond=0 -> pc=0x0011; pc=0xFFFF with INC -> pc=0x0000, no flag raised.
REQ-027: pc=0x0005, CALL target=0x0100 -> pc=0x0100, link=0x0006, level=1; then RET -> pc=0x0006, level=0, empty=1, link=0.
REQ-028: 5 CALLs with DEPTH=4 -> full=1 after the 4th; the 5th jumps to its target with ovf=1 and link still equal to the 4th return address; 4 RETs unwind in LIFO order; a 5th RET -> pc+1 and unf=1.
REQ-029: ovf=1 with clr_err=1 and en=0 -> ovf=0 next edge; clr_err=1 together with an overflowing CALL -> ovf stays 1.
REQ-030: rst pulsed low between clock edges at level=2 -> pc=RESET_PC, level=0 and errors=0 immediately, before the next clock edge.
